seq_addsub: RTL and testbench



---
 rtl/seq_addsub.sv | 119 +++++++++++
 tb/tb_seq_addsub.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that ripples a WIDTH-bit add
// through CHUNK-bit slices, LSB slice first, with a registered carry.
// ready/valid handshakes on both sides; one operation in flight at a time.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] opr0_i,
    input  logic [WIDTH-1:0] opr1_i,
    input  logic             minus_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_flag_o,
    output logic             pos_flag_o,
    output logic             neg_flag_o,
    output logic             carry_flag_o,
    output logic             overflow_flag_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands viewed as an array of chunks so the active slice is a plain index.
    logic [NCHUNK-1:0][CHUNK-1:0] opa;
    logic [NCHUNK-1:0][CHUNK-1:0] opb;
    logic [NCHUNK-1:0][CHUNK-1:0] res_q;
    logic                         carry;
    logic                         zero_acc;
    logic [CNT_W-1:0]             cnt;

    logic [CHUNK:0]               csum;
    logic                         last_chunk;
    logic                         res_msb;
    logic                         ovf;

    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign result_o   = res_q;
    assign last_chunk = (cnt == LAST_CHUNK);

    // One chunk of the ripple add; carry-in is the registered carry from the previous chunk.
    assign csum = {1'b0, opa[cnt]} + {1'b0, opb[cnt]} + {{CHUNK{1'b0}}, carry};

    // On the last chunk the slice MSB is the result MSB; B is already inverted for subtract.
    assign res_msb = csum[CHUNK-1];
    assign ovf     = (opa[NCHUNK-1][CHUNK-1] == opb[NCHUNK-1][CHUNK-1]) &&
                     (res_msb != opa[NCHUNK-1][CHUNK-1]);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, one chunk per cycle in BUSY, hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i)    state_nxt = BUSY;
            BUSY:    if (last_chunk) state_nxt = DONE;
            DONE:    if (ready_i)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-chunk carry/zero tracking; no reset needed since
    // every field is initialised on acceptance before it is used.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && valid_i) begin
            opa      <= opr0_i;
            opb      <= minus_i ? ~opr1_i : opr1_i;
            carry    <= minus_i;
            zero_acc <= 1'b1;
        end else if (state == BUSY) begin
            carry    <= csum[CHUNK];
            zero_acc <= zero_acc & (csum[CHUNK-1:0] == '0);
        end
    end

    // Result chunks, counter and flags; reset clears all visible outputs and aborts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q           <= '0;
            cnt             <= '0;
            zero_flag_o     <= 1'b0;
            pos_flag_o      <= 1'b0;
            neg_flag_o      <= 1'b0;
            carry_flag_o    <= 1'b0;
            overflow_flag_o <= 1'b0;
        end else if (state == IDLE) begin
            if (valid_i) cnt <= '0;
        end else if (state == BUSY) begin
            res_q[cnt] <= csum[CHUNK-1:0];
            cnt        <= last_chunk ? '0 : cnt + CNT_W'(1);
            if (last_chunk) begin
                zero_flag_o     <= zero_acc & (csum[CHUNK-1:0] == '0);
                neg_flag_o      <= res_msb;
                pos_flag_o      <= ~res_msb;
                carry_flag_o    <= csum[CHUNK];
                overflow_flag_o <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and model-checked bench for seq_addsub at three width/chunk
// configurations: 32/8 (4 chunks), 16/16 (single chunk), 64/4 (16 chunks).
module tb_seq_addsub;

    logic        clk;
    logic        rst;
    logic [63:0] opr0, opr1;
    logic        minus;
    logic        ready_in;
    logic [2:0]  vin;
    logic [2:0]  rdy, vout;
    logic [31:0] r32;
    logic [15:0] r16;
    logic [63:0] r64;
    logic [4:0]  f32, f16, f64;   // {zero, pos, neg, carry, overflow}

    int          sel;
    logic [63:0] res_s;
    logic [4:0]  fl_s;
    logic        rdy_s, vout_s;

    int n_tests = 0;
    int n_fail  = 0;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) u_d32 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rdy[0]),
        .opr0_i(opr0[31:0]), .opr1_i(opr1[31:0]), .minus_i(minus),
        .valid_o(vout[0]), .ready_i(ready_in), .result_o(r32),
        .zero_flag_o(f32[4]), .pos_flag_o(f32[3]), .neg_flag_o(f32[2]),
        .carry_flag_o(f32[1]), .overflow_flag_o(f32[0])
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) u_d16 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rdy[1]),
        .opr0_i(opr0[15:0]), .opr1_i(opr1[15:0]), .minus_i(minus),
        .valid_o(vout[1]), .ready_i(ready_in), .result_o(r16),
        .zero_flag_o(f16[4]), .pos_flag_o(f16[3]), .neg_flag_o(f16[2]),
        .carry_flag_o(f16[1]), .overflow_flag_o(f16[0])
    );

    seq_addsub #(.WIDTH(64), .CHUNK(4)) u_d64 (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[2]), .ready_o(rdy[2]),
        .opr0_i(opr0), .opr1_i(opr1), .minus_i(minus),
        .valid_o(vout[2]), .ready_i(ready_in), .result_o(r64),
        .zero_flag_o(f64[4]), .pos_flag_o(f64[3]), .neg_flag_o(f64[2]),
        .carry_flag_o(f64[1]), .overflow_flag_o(f64[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // View of the currently selected instance.
    always_comb begin
        res_s  = '0;
        fl_s   = '0;
        rdy_s  = 1'b0;
        vout_s = 1'b0;
        case (sel)
            0: begin res_s = {32'd0, r32}; fl_s = f32; rdy_s = rdy[0]; vout_s = vout[0]; end
            1: begin res_s = {48'd0, r16}; fl_s = f16; rdy_s = rdy[1]; vout_s = vout[1]; end
            2: begin res_s = r64;          fl_s = f64; rdy_s = rdy[2]; vout_s = vout[2]; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full-width reference: one add of WIDTH+1 bits, no chunking.
    function automatic void ref_op(input logic [63:0] a, input logic [63:0] b, input logic m,
                                   input int w, output logic [63:0] r, output logic [4:0] f);
        logic [63:0] mask, bb;
        logic [64:0] full;
        logic        msb, am, bm, c;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bb   = (m ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, m};
        r    = full[63:0] & mask;
        c    = full[w];
        msb  = r[w-1];
        am   = a[w-1];
        bm   = bb[w-1];
        f    = {(r == 64'd0), ~msb, msb, c, ((am == bm) && (msb != am))};
    endfunction

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] mask, v;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = mask >> 1;
            4:       v = 64'd1;
            default: v = {$urandom, $urandom} & mask;
        endcase
        return v;
    endfunction

    task automatic issue(input int s, input logic [63:0] a, input logic [63:0] b, input logic m);
        sel = s;
        #1;
        check("ready_idle", rdy_s, 1);
        opr0   = a;
        opr1   = b;
        minus  = m;
        vin[s] = 1'b1;
        @(posedge clk); #1;
        vin[s] = 1'b0;
        opr0   = ~a;
        opr1   = a ^ b;
        minus  = ~m;
    endtask

    task automatic wait_valid(input int lat, input bit poke, input string tag);
        int cyc = 0;
        while (vout_s !== 1'b1 && cyc < 40) begin
            if (poke) begin
                vin[sel] = 1'b1;
                opr0     = {$urandom, $urandom};
                check({tag, "_rdy_busy"}, rdy_s, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        vin = '0;
        check({tag, "_lat"}, cyc, lat);
    endtask

    task automatic check_out(input string tag, input logic [63:0] er, input logic [4:0] ef);
        check({tag, "_valid"}, vout_s, 1);
        check({tag, "_res"}, res_s, er);
        check({tag, "_flags"}, fl_s, ef);
    endtask

    task automatic release_out(input string tag);
        ready_in = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, vout_s, 0);
        check({tag, "_ready_back"}, rdy_s, 1);
    endtask

    task automatic run_full(input int s, input logic [63:0] a, input logic [63:0] b,
                            input logic m, input logic [63:0] er, input logic [4:0] ef,
                            input int lat, input string tag);
        issue(s, a, b, m);
        wait_valid(lat, 1'b0, tag);
        check_out(tag, er, ef);
        release_out(tag);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b, er;
        logic [4:0]  ef;
        logic        m;

        rst = 1'b1; vin = '0; ready_in = 1'b1; sel = 0;
        opr0 = '0; opr1 = '0; minus = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_valid", vout_s, 0);
            check("rst_ready", rdy_s, 1);
            check("rst_res", res_s, 0);
            check("rst_flags", fl_s, 0);
        end

        // Directed 32/8 vectors, flags = {zero,pos,neg,carry,ovf}.
        run_full(0, 64'h7FFFFFFF, 64'h00000001, 1'b0, 64'h80000000, 5'b00101, 4, "add_ovf");
        run_full(0, 64'hFFFFFFFF, 64'h00000001, 1'b0, 64'h00000000, 5'b11010, 4, "add_wrap");
        run_full(0, 64'h00000005, 64'h00000005, 1'b1, 64'h00000000, 5'b11010, 4, "sub_eq");
        run_full(0, 64'h00000003, 64'h00000005, 1'b1, 64'hFFFFFFFE, 5'b00100, 4, "sub_neg");
        run_full(0, 64'h80000000, 64'h00000001, 1'b1, 64'h7FFFFFFF, 5'b01011, 4, "sub_ovf");

        // Backpressure: requests poked during BUSY and DONE must be ignored.
        ready_in = 1'b0;
        issue(0, 64'h12345678, 64'h11111111, 1'b0);
        wait_valid(4, 1'b1, "bp");
        check_out("bp", 64'h23456789, 5'b01000);
        for (int i = 0; i < 10; i++) begin
            vin[0] = 1'b1;
            opr0   = {32'd0, $urandom};
            check("bp_rdy_done", rdy_s, 0);
            @(posedge clk); #1;
            check_out("bp_hold", 64'h23456789, 5'b01000);
        end
        vin = '0;
        release_out("bp");
        run_full(0, 64'h00000010, 64'h00000020, 1'b1, 64'hFFFFFFF0, 5'b00100, 4, "post_bp");

        // Reset in the middle of an operation (counter at 2).
        issue(0, 64'hFFFFFFFF, 64'h01010101, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", vout_s, 0);
        check("abort_ready", rdy_s, 1);
        check("abort_res", res_s, 0);
        check("abort_flags", fl_s, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_novalid", vout_s, 0);
        end
        run_full(0, 64'h80000000, 64'h00000001, 1'b1, 64'h7FFFFFFF, 5'b01011, 4, "post_abort");

        // Directed single-chunk and 16-chunk boundaries.
        run_full(1, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 5'b00101, 1, "d16_ovf");
        run_full(1, 64'h0000, 64'h0001, 1'b1, 64'hFFFF, 5'b00100, 1, "d16_sub");
        run_full(2, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 5'b11010, 16, "d64_wrap");
        run_full(2, 64'h8000000000000000, 64'h1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 5'b01011, 16,
                 "d64_sub_ovf");

        // Random operations against the full-width model.
        for (int i = 0; i < 200; i++) begin
            a = rnd_val(32); b = rnd_val(32); m = 1'($urandom_range(0, 1));
            ref_op(a, b, m, 32, er, ef);
            run_full(0, a, b, m, er, ef, 4, "r32");
        end
        for (int i = 0; i < 1000; i++) begin
            a = rnd_val(16); b = rnd_val(16); m = 1'($urandom_range(0, 1));
            ref_op(a, b, m, 16, er, ef);
            run_full(1, a, b, m, er, ef, 1, "r16");
        end
        for (int i = 0; i < 1000; i++) begin
            a = rnd_val(64); b = rnd_val(64); m = 1'($urandom_range(0, 1));
            ref_op(a, b, m, 64, er, ef);
            run_full(2, a, b, m, er, ef, 16, "r64");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
